// File: rtl/cordic_rot_arbiter_pkg.sv
// Shared constants and FSM encoding for the CORDIC rotate-core arbiter.
`timescale 1ns/1ps
package cordic_rot_arbiter_pkg;

  localparam int CORDIC_W         = 16;
  localparam int CORE_LAT_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_GAP     = 3'd4
  } state_t;

endpackage

// File: rtl/cordic_rot_arbiter_if.sv
// Requester/response bus between the DSP clients and the CORDIC arbiter.
`timescale 1ns/1ps
interface cordic_rot_arbiter_if
  import cordic_rot_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*CORDIC_W-1:0] req_angle;
  logic [NUM_REQ*CORDIC_W-1:0] req_x;
  logic [NUM_REQ*CORDIC_W-1:0] req_y;
  logic                        rsp_valid;
  logic [ID_W-1:0]             rsp_id;
  logic [CORDIC_W-1:0]         rsp_x;
  logic [CORDIC_W-1:0]         rsp_y;

  modport master (
    output req_valid, req_angle, req_x, req_y,
    input  req_ready, rsp_valid, rsp_id, rsp_x, rsp_y
  );

  modport slave (
    input  req_valid, req_angle, req_x, req_y,
    output req_ready, rsp_valid, rsp_id, rsp_x, rsp_y
  );

endinterface

// File: rtl/cordic_rot_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
`timescale 1ns/1ps
module cordic_rot_arbiter_rr #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               gnt_any
);

  int best_d;
  int d;

  // Distance from the pointer (mod NUM_REQ) ranks the requesters; smallest wins.
  always_comb begin
    best_d  = NUM_REQ;
    d       = 0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + NUM_REQ - int'(ptr));
      if (req[i] && (d < best_d)) begin
        best_d  = d;
        gnt_idx = ID_W'(i);
      end
    end
    gnt_any = (best_d < NUM_REQ);
    gnt     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i] = gnt_any && (gnt_idx == ID_W'(i));
    end
  end

endmodule

// File: rtl/cordic_rot_arbiter.sv
// Shares one fixed-latency CORDIC rotate core between NUM_REQ requesters.
//   state   | meaning
//   IDLE    | waiting; grant and latch operands of the round-robin winner
//   ISSUE   | core start pulse high for this cycle
//   WAIT    | counting core latency
//   CAPTURE | core result valid; register it into the response
//   GAP     | rsp_valid high; core settles before the next start
`timescale 1ns/1ps
module cordic_rot_arbiter
  import cordic_rot_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int CORE_LAT = CORE_LAT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  cordic_rot_arbiter_if.slave bus,
  output logic [CORDIC_W-1:0] cr_angle,
  output logic                cr_angle_valid,
  output logic [CORDIC_W-1:0] cr_x_in,
  output logic [CORDIC_W-1:0] cr_y_in,
  input  logic [CORDIC_W-1:0] cr_x_out,
  input  logic [CORDIC_W-1:0] cr_y_out,
  output logic                busy
);

  localparam int CNT_W = $clog2(CORE_LAT + 1);

  state_t              state;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     job_id;
  logic [CNT_W-1:0]    cnt;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_idx;
  logic                gnt_any;
  logic [ID_W-1:0]     ptr_nxt;
  logic [CORDIC_W-1:0] sel_angle;
  logic [CORDIC_W-1:0] sel_x;
  logic [CORDIC_W-1:0] sel_y;
  logic                rsp_valid;
  logic [ID_W-1:0]     rsp_id;
  logic [CORDIC_W-1:0] rsp_x;
  logic [CORDIC_W-1:0] rsp_y;

  cordic_rot_arbiter_rr #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req     (bus.req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    sel_angle = '0;
    sel_x     = '0;
    sel_y     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_angle = bus.req_angle[i*CORDIC_W +: CORDIC_W];
        sel_x     = bus.req_x[i*CORDIC_W +: CORDIC_W];
        sel_y     = bus.req_y[i*CORDIC_W +: CORDIC_W];
      end
    end
  end

  assign ptr_nxt       = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign bus.req_ready = (state == ST_IDLE) ? gnt : '0;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = rsp_id;
  assign bus.rsp_x     = rsp_x;
  assign bus.rsp_y     = rsp_y;
  assign busy          = (state != ST_IDLE);

  // Operand regs load only on a grant: the core re-samples them every iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      ptr            <= '0;
      job_id         <= '0;
      cnt            <= '0;
      cr_angle       <= '0;
      cr_x_in        <= '0;
      cr_y_in        <= '0;
      cr_angle_valid <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_id         <= '0;
      rsp_x          <= '0;
      rsp_y          <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            cr_angle       <= sel_angle;
            cr_x_in        <= sel_x;
            cr_y_in        <= sel_y;
            job_id         <= gnt_idx;
            ptr            <= ptr_nxt;
            cr_angle_valid <= 1'b1;
            state          <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cr_angle_valid <= 1'b0;
          cnt            <= CNT_W'(1);
          state          <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt == CNT_W'(CORE_LAT - 1)) begin
            state <= ST_CAPTURE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_CAPTURE: begin
          rsp_x     <= cr_x_out;
          rsp_y     <= cr_y_out;
          rsp_id    <= job_id;
          rsp_valid <= 1'b1;
          state     <= ST_GAP;
        end
        ST_GAP: begin
          rsp_valid <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_rot_arbiter.sv
// Directed bench for cordic_rot_arbiter with a fixed-latency behavioural core.
`timescale 1ns/1ps
module tb_cordic_rot_arbiter;
  import cordic_rot_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int LAT  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cordic_rot_arbiter_if #(.NUM_REQ(NREQ), .ID_W(IDW)) bus ();

  logic [15:0] cr_angle, cr_x_in, cr_y_in, cr_x_out, cr_y_out;
  logic        cr_angle_valid, busy;

  cordic_rot_arbiter #(.NUM_REQ(NREQ), .ID_W(IDW), .CORE_LAT(LAT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .cr_angle       (cr_angle),
    .cr_angle_valid (cr_angle_valid),
    .cr_x_in        (cr_x_in),
    .cr_y_in        (cr_y_in),
    .cr_x_out       (cr_x_out),
    .cr_y_out       (cr_y_out),
    .busy           (busy)
  );

  function automatic logic [15:0] core_fx(input logic [15:0] a, input logic [15:0] x, input logic [15:0] y);
    return x ^ {a[7:0], a[15:8]};
  endfunction

  function automatic logic [15:0] core_fy(input logic [15:0] a, input logic [15:0] x, input logic [15:0] y);
    return y + (x >> 1) - a;
  endfunction

  // Core model: result is only valid exactly LAT cycles after the start cycle.
  int core_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) core_cnt <= 0;
    else if (cr_angle_valid) core_cnt <= 1;
    else if (core_cnt != 0 && core_cnt < 1000) core_cnt <= core_cnt + 1;
  end
  always_comb begin
    cr_x_out = 16'hDEAD;
    cr_y_out = 16'hBEEF;
    if (core_cnt == LAT) begin
      cr_x_out = core_fx(cr_angle, cr_x_in, cr_y_in);
      cr_y_out = core_fy(cr_angle, cr_x_in, cr_y_in);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          acc_cyc[$];
  int          acc_idx[$];
  logic [3:0]  acc_rdy[$];
  logic [15:0] acc_ex[$];
  logic [15:0] acc_ey[$];
  int          st_cyc[$];
  int          rsp_cyc[$];
  int          rsp_idq[$];
  logic [15:0] rsp_xq[$];
  logic [15:0] rsp_yq[$];
  int          mon_k;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.req_ready != '0) begin
        mon_k = 0;
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) mon_k = i;
        acc_cyc.push_back(cyc);
        acc_idx.push_back(mon_k);
        acc_rdy.push_back(bus.req_ready);
        acc_ex.push_back(core_fx(bus.req_angle[16*mon_k +: 16], bus.req_x[16*mon_k +: 16], bus.req_y[16*mon_k +: 16]));
        acc_ey.push_back(core_fy(bus.req_angle[16*mon_k +: 16], bus.req_x[16*mon_k +: 16], bus.req_y[16*mon_k +: 16]));
      end
      if (cr_angle_valid) st_cyc.push_back(cyc);
      if (bus.rsp_valid) begin
        rsp_cyc.push_back(cyc);
        rsp_idq.push_back(int'(bus.rsp_id));
        rsp_xq.push_back(bus.rsp_x);
        rsp_yq.push_back(bus.rsp_y);
      end
    end
  end

  int checks = 0;
  int failures = 0;

  function automatic logic [88:0] outs_vec();
    return {bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_x, bus.rsp_y,
            cr_angle_valid, cr_angle, cr_x_in, cr_y_in, busy};
  endfunction

  task automatic clear_logs();
    acc_cyc.delete(); acc_idx.delete(); acc_rdy.delete(); acc_ex.delete(); acc_ey.delete();
    st_cyc.delete(); rsp_cyc.delete(); rsp_idq.delete(); rsp_xq.delete(); rsp_yq.delete();
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] x, input logic [15:0] y);
    bus.req_angle[16*i +: 16] = a;
    bus.req_x[16*i +: 16]     = x;
    bus.req_y[16*i +: 16]     = y;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_acc(input int n, input int budget);
    for (int c = 0; c < budget && acc_cyc.size() < n; c++) step();
  endtask

  task automatic wait_rsp(input int n, input int budget);
    for (int c = 0; c < budget && rsp_cyc.size() < n; c++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_angle = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    repeat (3) step();
    checks++;
    if (outs_vec() !== 89'd0) begin
      failures++;
      $display("FAIL reset_outputs_in_reset: got %h expected 0", outs_vec());
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (outs_vec() !== 89'd0) begin
      failures++;
      $display("FAIL reset_outputs_after_release: got %h expected 0", outs_vec());
    end
  endtask

  task automatic test_single();
    clear_logs();
    set_op(0, 16'h0000, 16'h4000, 16'h0000);
    bus.req_valid = 4'b0001;
    wait_acc(1, 10);
    bus.req_valid = '0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL single_busy: got %b expected 1", busy);
    end
    wait_rsp(1, 40);
    repeat (3) step();
    checks++;
    if (acc_cyc.size() != 1 || rsp_cyc.size() != 1 || st_cyc.size() != 1) begin
      failures++;
      $display("FAIL single_counts: acc %0d start %0d rsp %0d expected 1 1 1",
               acc_cyc.size(), st_cyc.size(), rsp_cyc.size());
    end else begin
      checks++;
      if (acc_rdy[0] !== 4'b0001) begin
        failures++;
        $display("FAIL single_ready: got %b expected 0001", acc_rdy[0]);
      end
      checks++;
      if (st_cyc[0] != acc_cyc[0] + 1) begin
        failures++;
        $display("FAIL single_start_cycle: got A+%0d expected A+1", st_cyc[0] - acc_cyc[0]);
      end
      checks++;
      if (rsp_cyc[0] != acc_cyc[0] + LAT + 2) begin
        failures++;
        $display("FAIL single_latency: got %0d expected %0d", rsp_cyc[0] - acc_cyc[0], LAT + 2);
      end
      checks++;
      if (rsp_idq[0] != 0 || rsp_xq[0] !== 16'h4000 || rsp_yq[0] !== 16'h2000) begin
        failures++;
        $display("FAIL single_result: got id %0d x %h y %h expected id 0 x 4000 y 2000",
                 rsp_idq[0], rsp_xq[0], rsp_yq[0]);
      end
    end
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_x !== 16'h4000 || bus.rsp_y !== 16'h2000) begin
      failures++;
      $display("FAIL single_hold: got valid %b x %h y %h expected 0 4000 2000",
               bus.rsp_valid, bus.rsp_x, bus.rsp_y);
    end
  endtask

  task automatic test_all_four();
    do_reset();
    clear_logs();
    for (int i = 0; i < NREQ; i++) set_op(i, 16'(16'h0100 * (i + 1)), 16'(16'h1000 + i), 16'(16'h0200 * i));
    bus.req_valid = 4'b1111;
    wait_acc(5, 120);
    bus.req_valid = '0;
    wait_rsp(5, 60);
    checks++;
    if (acc_cyc.size() != 5 || rsp_cyc.size() != 5) begin
      failures++;
      $display("FAIL all4_counts: acc %0d rsp %0d expected 5 5", acc_cyc.size(), rsp_cyc.size());
    end else begin
      for (int j = 0; j < 5; j++) begin
        checks++;
        if (acc_idx[j] != j % 4 || rsp_idq[j] != j % 4) begin
          failures++;
          $display("FAIL all4_order[%0d]: got grant %0d rsp_id %0d expected %0d", j, acc_idx[j], rsp_idq[j], j % 4);
        end
        checks++;
        if (rsp_xq[j] !== acc_ex[j] || rsp_yq[j] !== acc_ey[j]) begin
          failures++;
          $display("FAIL all4_result[%0d]: got %h %h expected %h %h", j, rsp_xq[j], rsp_yq[j], acc_ex[j], acc_ey[j]);
        end
        if (j > 0) begin
          checks++;
          if (acc_cyc[j] - acc_cyc[j-1] != LAT + 3) begin
            failures++;
            $display("FAIL all4_spacing[%0d]: got %0d expected %0d", j, acc_cyc[j] - acc_cyc[j-1], LAT + 3);
          end
        end
      end
    end
  endtask

  task automatic test_wrap();
    clear_logs();
    set_op(1, 16'h0010, 16'h0100, 16'h0020);
    bus.req_valid = 4'b0010;
    wait_acc(1, 10);
    bus.req_valid = '0;
    wait_rsp(1, 40);
    clear_logs();
    set_op(0, 16'h0003, 16'h0300, 16'h0030);
    bus.req_valid = 4'b0011;
    wait_acc(2, 60);
    bus.req_valid = '0;
    wait_rsp(2, 40);
    checks++;
    if (acc_cyc.size() != 2 || rsp_cyc.size() != 2) begin
      failures++;
      $display("FAIL wrap_counts: acc %0d rsp %0d expected 2 2", acc_cyc.size(), rsp_cyc.size());
    end else begin
      checks++;
      if (acc_idx[0] != 0 || acc_idx[1] != 1) begin
        failures++;
        $display("FAIL wrap_order: got %0d,%0d expected 0,1", acc_idx[0], acc_idx[1]);
      end
      checks++;
      if (rsp_idq[0] != 0 || rsp_idq[1] != 1) begin
        failures++;
        $display("FAIL wrap_rsp_id: got %0d,%0d expected 0,1", rsp_idq[0], rsp_idq[1]);
      end
    end
  endtask

  task automatic test_operand_stability();
    clear_logs();
    set_op(2, 16'h1234, 16'h0F0F, 16'h7001);
    bus.req_valid = 4'b0100;
    wait_acc(1, 10);
    bus.req_valid = '0;
    set_op(2, 16'hFFFF, 16'hAAAA, 16'h5555);
    for (int j = 0; j < 15; j++) begin
      step();
      checks++;
      if ({cr_angle, cr_x_in, cr_y_in} !== {16'h1234, 16'h0F0F, 16'h7001}) begin
        failures++;
        $display("FAIL operand_hold[%0d]: got %h %h %h expected 1234 0f0f 7001", j, cr_angle, cr_x_in, cr_y_in);
      end
    end
    wait_rsp(1, 20);
    checks++;
    if (rsp_cyc.size() != 1) begin
      failures++;
      $display("FAIL operand_rsp_count: got %0d expected 1", rsp_cyc.size());
    end else if (rsp_idq[0] != 2 || rsp_xq[0] !== 16'h3B1D || rsp_yq[0] !== 16'h6554) begin
      failures++;
      $display("FAIL operand_result: got id %0d x %h y %h expected id 2 x 3b1d y 6554",
               rsp_idq[0], rsp_xq[0], rsp_yq[0]);
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    set_op(3, 16'h0800, 16'h2000, 16'h1000);
    bus.req_valid = 4'b1000;
    wait_acc(1, 10);
    bus.req_valid = '0;
    repeat (7) step();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (outs_vec() !== 89'd0) begin
      failures++;
      $display("FAIL midreset_outputs: got %h expected 0", outs_vec());
    end
    step();
    step();
    rst_n = 1'b1;
    repeat (25) step();
    checks++;
    if (rsp_cyc.size() != 0) begin
      failures++;
      $display("FAIL midreset_no_rsp: got %0d responses expected 0", rsp_cyc.size());
    end
    clear_logs();
    set_op(1, 16'h0100, 16'h1000, 16'h0200);
    bus.req_valid = 4'b0010;
    wait_acc(1, 10);
    bus.req_valid = '0;
    wait_rsp(1, 40);
    checks++;
    if (acc_cyc.size() != 1 || rsp_cyc.size() != 1) begin
      failures++;
      $display("FAIL midreset_fresh_counts: acc %0d rsp %0d expected 1 1", acc_cyc.size(), rsp_cyc.size());
    end else begin
      checks++;
      if (rsp_cyc[0] - acc_cyc[0] != LAT + 2 || acc_idx[0] != 1) begin
        failures++;
        $display("FAIL midreset_fresh_latency: got %0d grant %0d expected %0d grant 1",
                 rsp_cyc[0] - acc_cyc[0], acc_idx[0], LAT + 2);
      end
      checks++;
      if (rsp_idq[0] != 1 || rsp_xq[0] !== 16'h1001 || rsp_yq[0] !== 16'h0900) begin
        failures++;
        $display("FAIL midreset_fresh_result: got id %0d x %h y %h expected id 1 x 1001 y 0900",
                 rsp_idq[0], rsp_xq[0], rsp_yq[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    set_op(1, 16'h2000, 16'h3000, 16'h0400);
    bus.req_valid = 4'b0010;
    wait_acc(2, 60);
    bus.req_valid = '0;
    wait_rsp(2, 40);
    checks++;
    if (acc_cyc.size() != 2 || rsp_cyc.size() != 2) begin
      failures++;
      $display("FAIL b2b_counts: acc %0d rsp %0d expected 2 2", acc_cyc.size(), rsp_cyc.size());
    end else begin
      checks++;
      if (acc_cyc[1] - acc_cyc[0] != LAT + 3) begin
        failures++;
        $display("FAIL b2b_spacing: got %0d expected %0d", acc_cyc[1] - acc_cyc[0], LAT + 3);
      end
      for (int j = 0; j < 2; j++) begin
        checks++;
        if (rsp_idq[j] != 1 || rsp_xq[j] !== 16'h3020 || rsp_yq[j] !== 16'hFC00) begin
          failures++;
          $display("FAIL b2b_result[%0d]: got id %0d x %h y %h expected id 1 x 3020 y fc00",
                   j, rsp_idq[j], rsp_xq[j], rsp_yq[j]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_wrap();
    test_operand_stability();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
